uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one UART transmitter serializer (8N1, CLKS_PER_BIT timing) among NUM_REQ byte sources.
- Accepts one byte at a time from the winning requester and launches it with a one-cycle strobe.
- Waits for the serializer's done pulse, then enforces an optional inter-frame gap before the next grant.
- Sits between the per-channel message logic and the single TX serializer on the shared UART line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CLKS, 0, idle clocks inserted after each frame's done pulse (0 = none).
- TIMEOUT_CLKS, 2048, watchdog limit in clocks from launch to i_Tx_Done; must exceed 10*CLKS_PER_BIT.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req_Valid  in  NUM_REQ  per-requester byte valid; held until accepted.
- i_Req_Byte  in  8*NUM_REQ  per-requester byte; requester k occupies bits [8k+7:8k].
- o_Req_Ready  out  NUM_REQ  one-hot accept pulse; transfer occurs when valid & ready.
- o_Tx_DV  out  1  one-cycle launch strobe to the serializer.
- o_Tx_Byte  out  8  byte to serialize; stable from the o_Tx_DV cycle until the frame ends.
- o_Tx_Src  out  log2(NUM_REQ) (min 1)  index of the requester owning the current frame.
- i_Tx_Done  in  1  serializer one-cycle pulse at the end of the stop bit.
- o_Busy  out  1  high in every state except IDLE.
- o_Timeout  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset values (asynchronous): state=IDLE, o_Req_Ready=0, o_Tx_DV=0, o_Tx_Byte=0, o_Tx_Src=0, o_Busy=0, o_Timeout=0, rr pointer=0, counters=0. Reset mid-frame abandons the frame; the serializer is not notified.
- States:
  - IDLE: when any i_Req_Valid is set, pick the winner by searching indices ptr, ptr+1, ... ptr+NUM_REQ-1 (mod NUM_REQ); the first set bit wins. Register o_Req_Ready[winner]=1 for exactly one cycle; latch the byte into o_Tx_Byte, winner into o_Tx_Src, and set ptr=(winner+1) mod NUM_REQ. Go to LAUNCH.
  - LAUNCH: o_Tx_DV=1 for this single cycle; clear the watchdog counter; go to WAIT_DONE.
  - WAIT_DONE:
    - On i_Tx_Done: go to GAP if GAP_CLKS>0, else IDLE.
    - Otherwise the counter increments; when it reaches TIMEOUT_CLKS-1, pulse o_Timeout for one cycle and take the same exit as done.
    - If i_Tx_Done and expiry coincide, done wins and no timeout pulse is issued.
  - GAP: count GAP_CLKS cycles, then go to IDLE.
- Latency:
  - Valid seen in IDLE at cycle N: o_Req_Ready high in cycle N+1, o_Tx_DV high in cycle N+2.
  - From i_Tx_Done in cycle D, the next o_Req_Ready is no earlier than cycle D+2+GAP_CLKS.
- o_Req_Ready is asserted only in the cycle after the IDLE decision. A requester that drops valid before being granted is simply not served; no error.
- Requests arriving during LAUNCH, WAIT_DONE or GAP wait; nothing is queued beyond the requesters' own valid/byte holding.
- i_Tx_Done outside WAIT_DONE is ignored.
- Single requester active: served back-to-back, one byte per frame; ptr wraps from NUM_REQ-1 to 0.
- o_Tx_Byte and o_Tx_Src change only at grant.
- Counter widths: sized by $clog2 of TIMEOUT_CLKS and of GAP_CLKS+1; no overflow, since each counter saturates at its exit condition.
- All outputs are registered.

Test Plan:
- Single requester: req 2 valid with 0xA5 -> ready[2] one cycle, o_Tx_DV next cycle with o_Tx_Byte=0xA5, o_Tx_Src=2; done pulse -> o_Busy falls (GAP_CLKS=0).
- Fairness: all 4 valid continuously (bytes 0x10,0x11,0x12,0x13), done 20 clocks after each DV -> grant order 0,1,2,3,0,1; each frame carries the matching byte.
- Gap: GAP_CLKS=5, two requesters pending -> second o_Req_Ready exactly 7 cycles after the first frame's i_Tx_Done.
- Watchdog: TIMEOUT_CLKS=64, never pulse done -> o_Timeout high exactly once, 64 clocks after o_Tx_DV; FSM returns to IDLE and serves the next requester.
- Coincidence: i_Tx_Done on the expiry cycle -> no o_Timeout; stray done while IDLE -> no effect.
- Reset mid-frame: assert i_Reset in WAIT_DONE -> all outputs 0 immediately (asynchronous), ptr=0; after release, req 3 and req 0 both valid -> req 0 granted first.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that feeds one shared 8N1 UART serializer from NUM_REQ byte sources.
// It grants one byte, launches it, waits for done or the watchdog, and then applies an optional inter-frame gap.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 2048
) (
  input  logic                                              i_Clock,
  input  logic                                              i_Reset,
  input  logic [NUM_REQ-1:0]                                i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]                              i_Req_Byte,
  output logic [NUM_REQ-1:0]                                o_Req_Ready,
  output logic                                              o_Tx_DV,
  output logic [7:0]                                        o_Tx_Byte,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_Tx_Src,
  input  logic                                              i_Tx_Done,
  output logic                                              o_Busy,
  output logic                                              o_Timeout
);

  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = SRC_W + 1;
  localparam int TO_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam bit               HAS_GAP  = (GAP_CLKS > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               dv_q, dv_d;
  logic [7:0]         byte_q, byte_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic               found_s;
  logic [SRC_W-1:0]   win_s;
  logic [IDX_W-1:0]   idx_s;
  logic [7:0]         win_byte_s;
  logic [7:0]         req_bytes_s [NUM_REQ];
  logic               expire_s;
  logic               gap_done_s;

  assign expire_s   = (to_cnt_q == TO_LAST);
  assign gap_done_s = (gap_cnt_q == GAP_LAST);

  // Unpack the flat byte bus so the winner can index it directly
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_bytes_s[k] = i_Req_Byte[8*k +: 8];
    end
  end

  // Rotating search from the pointer: the first valid requester wins
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = {1'b0, ptr_q} + IDX_W'(i);
      idx_s = (idx_s >= IDX_W'(NUM_REQ)) ? idx_s - IDX_W'(NUM_REQ) : idx_s;
      if (!found_s && i_Req_Valid[idx_s[SRC_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[SRC_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    win_byte_s = req_bytes_s[win_s];
  end

  // State register
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done takes priority over a coincident watchdog expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = found_s ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_Tx_Done || expire_s) begin
          state_d = HAS_GAP ? ST_GAP : ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_GAP:    state_d = gap_done_s ? ST_IDLE : ST_GAP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered from these
  always_comb begin
    ready_d   = '0;
    dv_d      = 1'b0;
    timeout_d = 1'b0;
    byte_d    = byte_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          ready_d[win_s] = 1'b1;
          byte_d         = win_byte_s;
          src_d          = win_s;
          ptr_d          = (win_s == SRC_W'(NUM_REQ - 1)) ? '0 : win_s + SRC_W'(1);
        end else begin
          ready_d = '0;
        end
      end
      ST_LAUNCH: begin
        dv_d     = 1'b1;
        to_cnt_d = '0;
      end
      ST_WAIT: begin
        if (i_Tx_Done) begin
          gap_cnt_d = '0;
        end else if (expire_s) begin
          timeout_d = 1'b1;
          gap_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_done_s) begin
          gap_cnt_d = gap_cnt_q;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        ready_d = '0;
      end
    endcase
  end

  // Registered outputs, pointer and counters
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      ready_q   <= '0;
      dv_q      <= 1'b0;
      byte_q    <= 8'h00;
      src_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      ready_q   <= ready_d;
      dv_q      <= dv_d;
      byte_q    <= byte_d;
      src_q     <= src_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign o_Req_Ready = ready_q;
  assign o_Tx_DV     = dv_q;
  assign o_Tx_Byte   = byte_q;
  assign o_Tx_Src    = src_q;
  assign o_Busy      = busy_q;
  assign o_Timeout   = timeout_q;

endmodule
